// File: rtl/onchip_memory_pipe.sv
// rtl/onchip_memory_pipe.sv - single-port Avalon-MM on-chip RAM, pipelined reads, post-reset zero fill
// Optional per-byte even parity with SLAVEERROR response: define ONCHIP_MEM_PARITY_EN.
module onchip_memory_pipe #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 12,
  parameter int DEPTH          = 4096,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                clken,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
`ifdef ONCHIP_MEM_PARITY_EN
  input  logic                parity_inject,
  output logic                parity_err,
  output logic [1:0]          readresponse,
`endif
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              clr_we;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  addr_idx, clr_idx;
  logic              in_range, accept, wr_acc, rd_acc;

  logic [DATA_W-1:0] rd_word_d;
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  assign waitrequest = (state_q == CLEAR) | reset;
  assign init_done   = (state_q == READY) & ~reset;

  assign in_range = ({1'b0, address} < DEPTH_C);
  assign addr_idx = address[IDX_W-1:0];
  assign clr_idx  = clr_cnt_q[IDX_W-1:0];
  assign accept   = chipselect & clken & ~waitrequest & (read | write);
  assign wr_acc   = accept & write;
  assign rd_acc   = accept & read & ~write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The fill ignores clken so the memory becomes usable in a fixed DEPTH cycles.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    if (state_q == CLEAR) begin
      clr_we    = ~reset;
      clr_cnt_d = clr_cnt_q + ONE_C;
      if (clr_cnt_q == LAST_C) begin
        state_d = READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx] <= '0;
    end else if (wr_acc && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (byteenable[i]) begin
          mem_q[addr_idx][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word_d = '0;
    if (rd_acc && in_range) begin
      rd_word_d = mem_q[addr_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else if (clken) begin
      s1_valid_q <= rd_acc;
      s1_data_q  <= rd_word_d;
    end
  end

`ifdef ONCHIP_MEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] rd_par_d, s1_par_q, out_par;
  logic          par_mismatch, rd_err, parity_err_q;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_q[clr_idx] <= '0;
    end else if (wr_acc && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (byteenable[i]) begin
          par_q[addr_idx][i] <= (^writedata[8*i +: 8]) ^ parity_inject;
        end
      end
    end
  end

  always_comb begin
    rd_par_d = '0;
    if (rd_acc && in_range) begin
      rd_par_d = par_q[addr_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_par_q <= '0;
    end else if (clken) begin
      s1_par_q <= rd_par_d;
    end
  end
`endif

  if (READ_LATENCY == 2) begin : g_lat2
    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_data_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else if (clken) begin
        s2_valid_q <= s1_valid_q;
        s2_data_q  <= s1_data_q;
      end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
`ifdef ONCHIP_MEM_PARITY_EN
    logic [NB-1:0] s2_par_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        s2_par_q <= '0;
      end else if (clken) begin
        s2_par_q <= s1_par_q;
      end
    end
    assign out_par = s2_par_q;
`endif
  end else begin : g_lat1
    assign out_valid = s1_valid_q;
    assign out_data  = s1_data_q;
`ifdef ONCHIP_MEM_PARITY_EN
    assign out_par   = s1_par_q;
`endif
  end

  // Gating with clken keeps a held last stage from pulsing more than once.
  assign readdatavalid = out_valid & clken;
  assign readdata      = out_data;

`ifdef ONCHIP_MEM_PARITY_EN
  always_comb begin
    par_mismatch = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if ((^out_data[8*i +: 8]) != out_par[i]) begin
        par_mismatch = 1'b1;
      end
    end
  end

  assign rd_err = readdatavalid & par_mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else if (rd_err) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err   = parity_err_q | rd_err;
  assign readresponse = rd_err ? 2'b10 : 2'b00;
`endif

endmodule

// File: tb/tb_onchip_memory_pipe.sv
// tb/tb_onchip_memory_pipe.sv - directed bench: DEPTH=12/latency 1 and DEPTH=16/latency 2 side by side
module tb_onchip_memory_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic [3:0]  byteenable = '0;
  logic        chipselect = 1'b0;
  logic        clken = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;

  logic [31:0] rd1, rd2;
  logic        rdv1, rdv2, wr1, wr2, id1, id2;
`ifdef ONCHIP_MEM_PARITY_EN
  logic        pinj = 1'b0;
  logic        perr1, perr2;
  logic [1:0]  rresp1, rresp2;
  logic [1:0]  qr2[$];
  logic        qe2[$];
`endif

  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          stall_bad = 0;
  logic [31:0] q1[$], q2[$];
  int          c1[$], c2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  onchip_memory_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .clken(clken), .read(read), .write(write), .writedata(writedata),
`ifdef ONCHIP_MEM_PARITY_EN
    .parity_inject(pinj), .parity_err(perr1), .readresponse(rresp1),
`endif
    .readdata(rd1), .readdatavalid(rdv1), .waitrequest(wr1), .init_done(id1)
  );

  onchip_memory_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .clken(clken), .read(read), .write(write), .writedata(writedata),
`ifdef ONCHIP_MEM_PARITY_EN
    .parity_inject(pinj), .parity_err(perr2), .readresponse(rresp2),
`endif
    .readdata(rd2), .readdatavalid(rdv2), .waitrequest(wr2), .init_done(id2)
  );

  always @(negedge clk) begin
    if (rdv1) begin q1.push_back(rd1); c1.push_back(cyc); end
    if (rdv2) begin q2.push_back(rd2); c2.push_back(cyc); end
`ifdef ONCHIP_MEM_PARITY_EN
    if (rdv2) begin qr2.push_back(rresp2); qe2.push_back(perr2); end
`endif
    if (!clken && (rdv1 || rdv2)) stall_bad++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_q();
    q1.delete(); q2.delete(); c1.delete(); c2.delete();
`ifdef ONCHIP_MEM_PARITY_EN
    qr2.delete(); qe2.delete();
`endif
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; chipselect = 1'b1; write = 1'b1;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output int acc);
    address = a; chipselect = 1'b1; read = 1'b1; acc = cyc;
    tick();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!(id1 && id2) && k < 100) begin tick(); k++; end
    check_eq("ready_timeout", {30'd0, id1, id2}, 32'd3);
  endtask

  // Counts waitrequest cycles from the cycle reset is released.
  task automatic count_clear(input string tag);
    int n1 = 0, n2 = 0, f2 = 0;
    reset = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (wr1) n1++;
      if (wr2) n2++;
      if (id2 && f2 == 0) f2 = k;
      @(posedge clk); #1;
    end
    check_eq({tag, "_wait12"}, n1, 12);
    check_eq({tag, "_wait16"}, n2, 16);
    check_eq({tag, "_init_cyc"}, f2, 17);
  endtask

  initial begin
    int acc;
    logic [31:0] exp1;

    tick(); tick();
    @(negedge clk);
    check_eq("rst_waitreq", {30'd0, wr1, wr2}, 32'd3);
    check_eq("rst_init_done", {30'd0, id1, id2}, 32'd0);
    check_eq("rst_rdv", {30'd0, rdv1, rdv2}, 32'd0);
    check_eq("rst_rdata1", rd1, 32'd0);
    check_eq("rst_rdata2", rd2, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ready();

    // Preload ones, then reset and verify the fill.
    for (int i = 0; i < 16; i++) bus_write(4'(i), 32'hFFFF_FFFF, 4'hF);
    reset = 1'b1;
    tick(); tick();
    count_clear("clear");
    flush_q();
    address = '0; chipselect = 1'b1; read = 1'b1;
    for (int i = 0; i < 16; i++) begin address = 4'(i); tick(); end
    chipselect = 1'b0; read = 1'b0;
    repeat (4) tick();
    check_eq("clear_cnt1", q1.size(), 16);
    check_eq("clear_cnt2", q2.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("clear_w%0d_d2", i), q2[i], 32'd0);
      check_eq($sformatf("clear_w%0d_d1", i), q1[i], 32'd0);
    end

    // Byte-enable merge and latency.
    bus_write(4'd3, 32'h1122_3344, 4'hF);
    bus_write(4'd3, 32'hAABB_CCDD, 4'b0101);
    flush_q();
    bus_read(4'd3, acc);
    repeat (4) tick();
    check_eq("be_cnt", {q1.size(), q2.size()} == {32'd1, 32'd1}, 32'd1);
    check_eq("be_data1", q1[0], 32'h11BB_33DD);
    check_eq("be_data2", q2[0], 32'h11BB_33DD);
    check_eq("lat1", c1[0] - acc, 32'd1);
    check_eq("lat2", c2[0] - acc, 32'd2);

    // Streaming with a 3-cycle clken stall mid-stream.
    for (int i = 0; i < 8; i++) bus_write(4'(i), 32'hC0DE_0000 + i, 4'hF);
    flush_q();
    stall_bad = 0;
    chipselect = 1'b1; read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      address = 4'(i);
      if (i == 4) begin clken = 1'b0; repeat (3) tick(); clken = 1'b1; end
      tick();
    end
    chipselect = 1'b0; read = 1'b0;
    repeat (4) tick();
    check_eq("stream_cnt1", q1.size(), 8);
    check_eq("stream_cnt2", q2.size(), 8);
    check_eq("stall_pulses", stall_bad, 0);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("stream%0d_d1", i), q1[i], 32'hC0DE_0000 + i);
      check_eq($sformatf("stream%0d_d2", i), q2[i], 32'hC0DE_0000 + i);
    end

    // Reset during the fill restarts it.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    count_clear("midclr");

    // Read and write together: write wins, no read response.
    flush_q();
    address = 4'd2; writedata = 32'h5; byteenable = 4'hF;
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    tick();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    repeat (4) tick();
    check_eq("rw_no_rdv", q1.size() + q2.size(), 32'd0);
    bus_read(4'd2, acc);
    repeat (4) tick();
    check_eq("rw_data1", q1[0], 32'h5);
    check_eq("rw_data2", q2[0], 32'h5);

    // Address 13 is out of range for dut1 only.
    bus_write(4'd13, 32'hDEAD, 4'hF);
    flush_q();
    bus_read(4'd13, acc);
    repeat (4) tick();
    check_eq("oor_cnt1", q1.size(), 1);
    check_eq("oor_data1", q1[0], 32'h0);
    check_eq("oor_data2", q2[0], 32'hDEAD);
    flush_q();
    chipselect = 1'b1; read = 1'b1;
    for (int i = 0; i < 12; i++) begin address = 4'(i); tick(); end
    chipselect = 1'b0; read = 1'b0;
    repeat (4) tick();
    check_eq("oor_scan_cnt", q1.size(), 12);
    for (int i = 0; i < 12; i++) begin
      exp1 = (i == 2) ? 32'h5 : 32'h0;
      check_eq($sformatf("oor_w%0d", i), q1[i], exp1);
    end

`ifdef ONCHIP_MEM_PARITY_EN
    pinj = 1'b1;
    bus_write(4'd4, 32'h1234_5678, 4'hF);
    pinj = 1'b0;
    bus_write(4'd5, 32'h0F0F_0101, 4'hF);
    flush_q();
    check_eq("par_pre", {31'd0, perr2}, 32'd0);
    bus_read(4'd4, acc);
    bus_read(4'd5, acc);
    repeat (4) tick();
    check_eq("par_cnt", qr2.size(), 2);
    check_eq("par_resp_bad", {30'd0, qr2[0]}, 32'd2);
    check_eq("par_err_set", {31'd0, qe2[0]}, 32'd1);
    check_eq("par_resp_ok", {30'd0, qr2[1]}, 32'd0);
    check_eq("par_err_sticky", {31'd0, perr2}, 32'd1);
    check_eq("par_err_d1", {31'd0, perr1}, 32'd1);
    reset = 1'b1;
    tick();
    check_eq("par_err_rst", {30'd0, perr1, perr2}, 32'd0);
    reset = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
